// File: rtl/retire_stage.sv
// In-order retire stage: commits the ROB head combinationally; only a store holds the head in STORE_WAIT until mem_ack.
// ir_stall back-pressures the ROB during stores and forever after halt. Define RETIRE_TRACE_EN to add the writeback trace ports.
module retire_stage #(
  parameter int XLEN       = 32,
  parameter int PREG_IDX_W = 6,
  parameter int CNT_W      = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  retire_en,
  input  logic [PREG_IDX_W:0]   retire_t,
  input  logic [PREG_IDX_W:0]   retire_t_old,
  input  logic [4:0]            dest_reg_idx,
  input  logic                  halt,
  input  logic                  wr_mem,
  input  logic                  take_branch,
  input  logic [XLEN-1:0]       result,
  input  logic [XLEN-1:0]       rs2_value,
  input  logic [XLEN-1:0]       NPC,
  output logic                  ir_stall,
  output logic                  free_en,
  output logic [PREG_IDX_W-1:0] free_tag,
  output logic                  amt_wr_en,
  output logic [4:0]            amt_idx,
  output logic [PREG_IDX_W-1:0] amt_tag,
  output logic                  mem_req,
  output logic [XLEN-1:0]       mem_addr,
  output logic [XLEN-1:0]       mem_data,
  input  logic                  mem_ack,
  output logic                  squash_en,
  output logic [XLEN-1:0]       squash_pc,
  output logic                  halted,
  output logic [CNT_W-1:0]      retired_count
`ifdef RETIRE_TRACE_EN
  ,
  output logic                  trace_valid,
  output logic [4:0]            trace_reg_idx,
  output logic [XLEN-1:0]       trace_data,
  output logic [XLEN-1:0]       trace_npc
`endif
);

  typedef struct packed {
    logic                  valid;
    logic [PREG_IDX_W-1:0] idx;
  } tag_t;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    STORE_WAIT = 2'd1,
    HALTED     = 2'd2
  } state_e;

  state_e state;
  tag_t   t_new;
  tag_t   t_old;

  logic commit;
  logic store_commit;
  logic store_accept;
  logic go_halt;
  logic squash;

  assign t_new = retire_t;
  assign t_old = retire_t_old;

  always_comb begin
    ir_stall     = 1'b0;
    commit       = 1'b0;
    store_commit = 1'b0;
    store_accept = 1'b0;
    go_halt      = 1'b0;
    squash       = 1'b0;
    case (state)
      RUN: begin
        if (retire_en) begin
          if (halt) begin
            commit  = 1'b1;
            go_halt = 1'b1;
          end else if (wr_mem) begin
            // Stores ignore take_branch and hold the head until the ack.
            ir_stall     = 1'b1;
            store_accept = 1'b1;
          end else begin
            commit = 1'b1;
            squash = take_branch;
          end
        end
      end
      STORE_WAIT: begin
        ir_stall = !mem_ack;
        if (mem_ack) begin
          commit       = 1'b1;
          store_commit = 1'b1;
        end
      end
      default: ir_stall = 1'b1;
    endcase
  end

  // Stores never write the map table; their destination tag is invalid.
  assign free_en   = commit && t_old.valid;
  assign free_tag  = free_en ? t_old.idx : '0;
  assign amt_wr_en = commit && !store_commit && t_new.valid && (dest_reg_idx != 5'd0);
  assign amt_idx   = amt_wr_en ? dest_reg_idx : 5'd0;
  assign amt_tag   = amt_wr_en ? t_new.idx : '0;
  assign squash_en = squash;
  assign squash_pc = squash ? result : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= RUN;
      retired_count <= '0;
      mem_req       <= 1'b0;
      mem_addr      <= '0;
      mem_data      <= '0;
      halted        <= 1'b0;
    end else begin
      if (commit) begin
        retired_count <= retired_count + CNT_W'(1);
      end
      case (state)
        RUN: begin
          if (store_accept) begin
            mem_addr <= result;
            mem_data <= rs2_value;
            mem_req  <= 1'b1;
            state    <= STORE_WAIT;
          end else if (go_halt) begin
            halted <= 1'b1;
            state  <= HALTED;
          end
        end
        STORE_WAIT: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= RUN;
          end
        end
        HALTED: begin
          halted <= 1'b1;
        end
        default: begin
          mem_req <= 1'b0;
          state   <= RUN;
        end
      endcase
    end
  end

`ifdef RETIRE_TRACE_EN
  assign trace_valid   = commit;
  assign trace_reg_idx = commit ? dest_reg_idx : 5'd0;
  assign trace_data    = !commit ? '0 : (store_commit ? mem_data : result);
  assign trace_npc     = commit ? NPC : '0;
`else
  logic unused_npc;
  assign unused_npc = ^NPC;
`endif

endmodule

// File: tb/tb_retire_stage.sv
// Randomized scoreboard bench for retire_stage: stimulus pushes expected retirements and stores, a negedge monitor pops and compares.
module tb_retire_stage;
  localparam int XLEN = 32;
  localparam int PW   = 6;
  localparam int CW   = 32;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            retire_en = 1'b0;
  logic [PW:0]     retire_t = '0;
  logic [PW:0]     retire_t_old = '0;
  logic [4:0]      dest_reg_idx = '0;
  logic            halt = 1'b0;
  logic            wr_mem = 1'b0;
  logic            take_branch = 1'b0;
  logic [XLEN-1:0] result = '0;
  logic [XLEN-1:0] rs2_value = '0;
  logic [XLEN-1:0] NPC = '0;
  logic            mem_ack = 1'b0;
  logic            ir_stall, free_en, amt_wr_en, mem_req, squash_en, halted;
  logic [PW-1:0]   free_tag, amt_tag;
  logic [4:0]      amt_idx;
  logic [XLEN-1:0] mem_addr, mem_data, squash_pc;
  logic [CW-1:0]   retired_count;

  always #5 clock = ~clock;

  retire_stage dut (
    .clock(clock), .reset(reset), .retire_en(retire_en), .retire_t(retire_t),
    .retire_t_old(retire_t_old), .dest_reg_idx(dest_reg_idx), .halt(halt),
    .wr_mem(wr_mem), .take_branch(take_branch), .result(result),
    .rs2_value(rs2_value), .NPC(NPC), .ir_stall(ir_stall), .free_en(free_en),
    .free_tag(free_tag), .amt_wr_en(amt_wr_en), .amt_idx(amt_idx),
    .amt_tag(amt_tag), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_ack(mem_ack), .squash_en(squash_en),
    .squash_pc(squash_pc), .halted(halted), .retired_count(retired_count)
  );

  typedef struct {
    logic            free_en;
    logic [PW-1:0]   free_tag;
    logic            amt_wr_en;
    logic [4:0]      amt_idx;
    logic [PW-1:0]   amt_tag;
    logic            squash_en;
    logic [XLEN-1:0] squash_pc;
    logic [CW-1:0]   count;
  } exp_t;

  typedef struct {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
  } st_t;

  exp_t          exp_q[$];
  st_t           st_q[$];
  int            n_checks = 0;
  int            n_fail = 0;
  logic [CW-1:0] model_count = '0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic req);
    check32(name, 32'(act), 32'(req));
  endtask

  // Reference rules for one retirement; the sequence number is the expected counter value afterwards.
  task automatic model_retire(input bit is_store, input bit is_halt, input logic [PW:0] t,
                              input logic [PW:0] t_old, input logic [4:0] d, input logic br,
                              input logic [XLEN-1:0] res);
    exp_t e;
    model_count   = model_count + 1;
    e.free_en     = t_old[PW];
    e.free_tag    = t_old[PW-1:0];
    e.amt_wr_en   = !is_store && t[PW] && (d != 5'd0);
    e.amt_idx     = d;
    e.amt_tag     = t[PW-1:0];
    e.squash_en   = br && !is_store && !is_halt;
    e.squash_pc   = res;
    e.count       = model_count;
    exp_q.push_back(e);
  endtask

  // Monitor: pops an expectation whenever the DUT commits.
  exp_t            mon_e;
  st_t             mon_st;
  logic [CW-1:0]   mon_count = '0;
  logic            mon_prev_req = 1'b0;

  always @(negedge clock) begin
    if (reset) begin
      mon_count    = '0;
      mon_prev_req = 1'b0;
    end else begin
      check32("retired_count", retired_count, mon_count);
      if ((retire_en && !ir_stall) || (mem_req && mem_ack)) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_retire: got a commit, expected none (t=%0t)", $time);
        end else begin
          mon_e = exp_q.pop_front();
          check1("free_en", free_en, mon_e.free_en);
          if (mon_e.free_en) check32("free_tag", 32'(free_tag), 32'(mon_e.free_tag));
          check1("amt_wr_en", amt_wr_en, mon_e.amt_wr_en);
          if (mon_e.amt_wr_en) begin
            check32("amt_idx", 32'(amt_idx), 32'(mon_e.amt_idx));
            check32("amt_tag", 32'(amt_tag), 32'(mon_e.amt_tag));
          end
          check1("squash_en", squash_en, mon_e.squash_en);
          if (mon_e.squash_en) check32("squash_pc", squash_pc, mon_e.squash_pc);
          mon_count = mon_e.count;
        end
      end else begin
        check1("idle_free_en", free_en, 1'b0);
        check1("idle_amt_wr_en", amt_wr_en, 1'b0);
        check1("idle_squash_en", squash_en, 1'b0);
      end
      if (mem_req) begin
        if (!mon_prev_req) begin
          if (st_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_mem_req: got mem_req=1, expected 0 (t=%0t)", $time);
          end else begin
            mon_st = st_q.pop_front();
          end
        end
        check32("mem_addr", mem_addr, mon_st.addr);
        check32("mem_data", mem_data, mon_st.data);
      end
      mon_prev_req = mem_req;
    end
  end

  // All driver tasks start and end 1 time unit after a rising edge.
  task automatic clear_inputs();
    retire_en   = 1'b0;
    halt        = 1'b0;
    wr_mem      = 1'b0;
    take_branch = 1'b0;
    mem_ack     = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    exp_q.delete();
    st_q.delete();
    model_count = '0;
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic drive(input logic h, input logic w, input logic br, input logic [PW:0] t,
                       input logic [PW:0] t_old, input logic [4:0] d,
                       input logic [XLEN-1:0] res, input logic [XLEN-1:0] rs2);
    retire_en    = 1'b1;
    halt         = h;
    wr_mem       = w;
    take_branch  = br;
    retire_t     = t;
    retire_t_old = t_old;
    dest_reg_idx = d;
    result       = res;
    rs2_value    = rs2;
    NPC          = $urandom;
  endtask

  task automatic issue_alu(input logic [PW:0] t, input logic [PW:0] t_old, input logic [4:0] d,
                           input logic br, input logic [XLEN-1:0] res);
    drive(1'b0, 1'b0, br, t, t_old, d, res, $urandom);
    mem_ack = ($urandom_range(3) == 0);
    model_retire(1'b0, 1'b0, t, t_old, d, br, res);
    @(negedge clock);
    check1("alu_ir_stall", ir_stall, 1'b0);
    next_cycle();
    clear_inputs();
  endtask

  task automatic issue_store(input logic [PW:0] t_old, input logic [4:0] d, input logic br,
                             input logic [XLEN-1:0] addr, input logic [XLEN-1:0] data,
                             input int delay);
    st_t s;
    logic [PW:0] t_inv;
    t_inv = {1'b0, PW'($urandom)};
    s.addr = addr;
    s.data = data;
    st_q.push_back(s);
    drive(1'b0, 1'b1, br, t_inv, t_old, d, addr, data);
    model_retire(1'b1, 1'b0, t_inv, t_old, d, br, addr);
    @(negedge clock);
    check1("store_ir_stall_first", ir_stall, 1'b1);
    check1("store_req_not_yet", mem_req, 1'b0);
    for (int i = 0; i <= delay; i++) begin
      next_cycle();
      mem_ack = (i == delay);
      // Wiggle the operand inputs to prove the request is taken from the latch.
      result    = $urandom;
      rs2_value = $urandom;
      @(negedge clock);
      check1("store_ir_stall", ir_stall, !mem_ack);
      check1("store_mem_req", mem_req, 1'b1);
    end
    next_cycle();
    clear_inputs();
    @(negedge clock);
    check1("store_req_drop", mem_req, 1'b0);
    next_cycle();
  endtask

  task automatic issue_halt();
    logic [PW:0] t_inv;
    logic [PW:0] told_inv;
    t_inv    = {1'b0, PW'($urandom)};
    told_inv = {1'b0, PW'($urandom)};
    drive(1'b1, 1'b0, 1'b0, t_inv, told_inv, 5'($urandom), $urandom, $urandom);
    model_retire(1'b0, 1'b1, t_inv, told_inv, dest_reg_idx, 1'b0, result);
    @(negedge clock);
    check1("halt_ir_stall", ir_stall, 1'b0);
    next_cycle();
    clear_inputs();
    @(negedge clock);
    check1("halted_set", halted, 1'b1);
    check1("halted_stall", ir_stall, 1'b1);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      drive(1'b0, 1'b0, 1'b1, {1'b1, PW'($urandom)}, {1'b1, PW'($urandom)}, 5'd4, $urandom, $urandom);
      mem_ack = 1'b1;
      @(negedge clock);
      check1("halted_hold", halted, 1'b1);
      check1("halted_hold_stall", ir_stall, 1'b1);
    end
    next_cycle();
    clear_inputs();
  endtask

  initial begin
    next_cycle();
    do_reset();
    @(negedge clock);
    check1("rst_ir_stall", ir_stall, 1'b0);
    check1("rst_mem_req", mem_req, 1'b0);
    check32("rst_mem_addr", mem_addr, 32'h0);
    check32("rst_mem_data", mem_data, 32'h0);
    check1("rst_halted", halted, 1'b0);
    check32("rst_count", retired_count, 32'h0);
    next_cycle();

    issue_alu({1'b1, 6'd12}, {1'b1, 6'd5}, 5'd3, 1'b0, 32'h1234);
    issue_alu({1'b1, 6'd7}, {1'b1, 6'd9}, 5'd0, 1'b0, 32'h55);
    issue_store({1'b1, 6'd20}, 5'd0, 1'b0, 32'h100, 32'hDEAD, 3);
    issue_alu({1'b1, 6'd30}, {1'b0, 6'd2}, 5'd7, 1'b1, 32'h40);
    issue_store({1'b0, 6'd0}, 5'd0, 1'b1, 32'h200, 32'hBEEF, 0);

    for (int n = 0; n < 400; n++) begin
      logic [4:0] d;
      d = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom);
      if ($urandom_range(7) < 2)
        issue_store({1'($urandom), PW'($urandom)}, d, 1'($urandom), $urandom, $urandom,
                    int'($urandom_range(4)));
      else
        issue_alu({1'($urandom), PW'($urandom)}, {1'($urandom), PW'($urandom)}, d,
                  ($urandom_range(3) == 0), $urandom);
      if ($urandom_range(3) == 0) next_cycle();
    end

    issue_halt();
    do_reset();
    @(negedge clock);
    check1("post_halt_reset_halted", halted, 1'b0);
    check1("post_halt_reset_stall", ir_stall, 1'b0);
    next_cycle();
    issue_alu({1'b1, 6'd1}, {1'b1, 6'd2}, 5'd1, 1'b0, 32'h8);

    // Reset while a store waits for its ack: no commit, request drops.
    st_q.push_back('{addr: 32'h300, data: 32'hCAFE});
    drive(1'b0, 1'b1, 1'b0, {1'b0, 6'd0}, {1'b1, 6'd3}, 5'd0, 32'h300, 32'hCAFE);
    next_cycle();
    next_cycle();
    do_reset();
    @(negedge clock);
    check1("rst_store_mem_req", mem_req, 1'b0);
    check1("rst_store_stall", ir_stall, 1'b0);
    next_cycle();
    mem_ack = 1'b1;
    @(negedge clock);
    check1("late_ack_mem_req", mem_req, 1'b0);
    next_cycle();
    mem_ack = 1'b0;
    next_cycle();
    @(negedge clock);

    check32("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check32("st_q_drained", 32'(st_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
